// File: rtl/dptr_pipe.sv
// Two-stage pipelined MIPS R-type datapath: decode/operand fetch into an ID/EX
// register, then a registered ALU/writeback stage with a single forwarding path.
module dptr_pipe #(
  parameter int DATA_W = 32,
  parameter int REGS   = 32,
  localparam int REG_AW = $clog2(REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [31:0]       instr,
  input  logic              ld_en,
  input  logic [REG_AW-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              res_valid,
  output logic [4:0]        res_rd,
  output logic [DATA_W-1:0] res_data,
  output logic              res_zf,
  output logic              res_ill
);

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] REGS_L = 6'(REGS);

  function automatic logic funct_ok(input logic [5:0] f);
    logic ok;
    case (f)
      F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_SLT, F_SLL, F_SRL: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [DATA_W-1:0] alu_fn(input logic [5:0] f, input logic [4:0] sh,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    case (f)
      F_ADD:   r = a + b;
      F_SUB:   r = a - b;
      F_AND:   r = a & b;
      F_OR:    r = a | b;
      F_NOR:   r = ~(a | b);
      F_SLT:   r = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      F_SLL:   r = b << sh;
      F_SRL:   r = b >> sh;
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [DATA_W-1:0] bank_r [REGS];

  logic              s1_valid_r;
  logic              s1_legal_r;
  logic [5:0]        s1_funct_r;
  logic [4:0]        s1_shamt_r;
  logic [4:0]        s1_rd_r;
  logic [DATA_W-1:0] s1_a_r;
  logic [DATA_W-1:0] s1_b_r;

  logic              res_valid_r;
  logic [4:0]        res_rd_r;
  logic [DATA_W-1:0] res_data_r;
  logic              res_zf_r;
  logic              res_ill_r;

  logic [5:0]        op_s;
  logic [4:0]        rs_s;
  logic [4:0]        rt_s;
  logic [4:0]        rd_s;
  logic              legal_s;
  logic [DATA_W-1:0] alu_s;
  logic              wb_en_s;
  logic [DATA_W-1:0] opa_s;
  logic [DATA_W-1:0] opb_s;

  assign op_s = instr[31:26];
  assign rs_s = instr[25:21];
  assign rt_s = instr[20:16];
  assign rd_s = instr[15:11];

  assign legal_s = (op_s == 6'd0) && ({1'b0, rs_s} < REGS_L) && ({1'b0, rt_s} < REGS_L)
                   && ({1'b0, rd_s} < REGS_L) && funct_ok(instr[5:0]);

  assign alu_s   = alu_fn(s1_funct_r, s1_shamt_r, s1_a_r, s1_b_r);
  // Only a retiring legal instruction with a nonzero destination writes or forwards.
  assign wb_en_s = s1_valid_r && s1_legal_r && (s1_rd_r != 5'd0);

  // Operand A: forward from the retiring instruction, else bank with r0 forced to zero.
  always_comb begin
    opa_s = '0;
    if (wb_en_s && (rs_s == s1_rd_r)) begin
      opa_s = alu_s;
    end else if (rs_s == 5'd0) begin
      opa_s = '0;
    end else begin
      opa_s = bank_r[rs_s[REG_AW-1:0]];
    end
  end

  // Operand B: same selection as operand A on the rt field.
  always_comb begin
    opb_s = '0;
    if (wb_en_s && (rt_s == s1_rd_r)) begin
      opb_s = alu_s;
    end else if (rt_s == 5'd0) begin
      opb_s = '0;
    end else begin
      opb_s = bank_r[rt_s[REG_AW-1:0]];
    end
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_legal_r <= 1'b0;
      s1_funct_r <= 6'd0;
      s1_shamt_r <= 5'd0;
      s1_rd_r    <= 5'd0;
      s1_a_r     <= '0;
      s1_b_r     <= '0;
    end else begin
      s1_valid_r <= in_valid;
      s1_legal_r <= legal_s;
      s1_funct_r <= instr[5:0];
      s1_shamt_r <= instr[10:6];
      s1_rd_r    <= rd_s;
      s1_a_r     <= opa_s;
      s1_b_r     <= opb_s;
    end
  end

  // Result register; a bubble clears res_valid and leaves the other fields alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_r <= 1'b0;
      res_rd_r    <= 5'd0;
      res_data_r  <= '0;
      res_zf_r    <= 1'b0;
      res_ill_r   <= 1'b0;
    end else begin
      res_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        res_rd_r   <= s1_rd_r;
        res_ill_r  <= !s1_legal_r;
        res_data_r <= s1_legal_r ? alu_s : '0;
        res_zf_r   <= s1_legal_r && (alu_s == '0);
      end else begin
        res_rd_r   <= res_rd_r;
        res_ill_r  <= res_ill_r;
        res_data_r <= res_data_r;
        res_zf_r   <= res_zf_r;
      end
    end
  end

  // Register bank: writeback has priority over the load port on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REGS; i++) begin
        bank_r[i] <= '0;
      end
    end else if (wb_en_s) begin
      bank_r[s1_rd_r[REG_AW-1:0]] <= alu_s;
    end else if (ld_en && (ld_addr != '0)) begin
      bank_r[ld_addr] <= ld_data;
    end else begin
      bank_r[0] <= '0;
    end
  end

  assign dbg_data  = bank_r[dbg_addr];
  assign res_valid = res_valid_r;
  assign res_rd    = res_rd_r;
  assign res_data  = res_data_r;
  assign res_zf    = res_zf_r;
  assign res_ill   = res_ill_r;

endmodule

// File: doc/dptr_pipe.md
# dptr_pipe

Parametrised, pipelined successor to the combinational R-type datapath. Accepts one MIPS R-type instruction per cycle, reads operands from an internal register bank, executes in a registered ALU stage and writes back with a single forwarding path, so back-to-back dependent instructions need no stalls. It sits between instruction fetch and the rest of the processor, and has load/debug ports so benches can preload and inspect the register bank without hierarchical access.

## Interface
- DATA_W, 32: register and ALU width, 8..64.
- REGS, 32: register bank depth, a power of two, 2..32; REG_AW = clog2(REGS).
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  instr is valid this cycle.
- instr  in  32  {op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0]}.
- ld_en  in  1  register-bank load strobe.
- ld_addr  in  REG_AW  load address.
- ld_data  in  DATA_W  load data.
- dbg_addr  in  REG_AW  debug read address.
- dbg_data  out  DATA_W  combinational read of bank[dbg_addr].
- res_valid  out  1  result of a retired instruction.
- res_rd  out  5  destination field of that instruction.
- res_data  out  DATA_W  ALU result.
- res_zf  out  1  res_data == 0 (TR_ZF successor).
- res_ill  out  1  instruction was illegal; nothing was written.

## Operation
- Stage 1 (ID/EX register, edge k): captures valid, funct, shamt, rd, legality and operands A = R[rs], B = R[rt].
- Stage 2 (EX/WB, edge k+1): ALU result computed combinationally from the stage-1 registers. At edge k+1 it is registered onto res_* and written to R[rd].
- Legal instructions have op == 0, rs/rt/rd < REGS, and funct in the set below; any other instruction sets res_ill = 1, res_data = 0 and res_zf = 0, with no write and no forward.
- funct decode:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 100111 nor: all wrap modulo 2^DATA_W, no overflow trap.
  - 101010 slt: signed compare, result 1 or 0, zero-extended.
  - 000000 sll: B << shamt.
  - 000010 srl: B >> shamt (logical).
  - shamt is ignored for non-shift ops.
- Register 0 reads as 0. Writes and loads to address 0 are discarded, and address 0 is never forwarded.
- Forwarding: if the stage-2 instruction is valid, legal and has rd ≠ 0, any stage-1 read of rs/rt equal to that rd takes the ALU output instead of the bank. An instruction two or more slots younger reads the already-written bank.
- Load port: at each edge with ld_en, R[ld_addr] = ld_data. If a pipeline writeback targets the same edge, the writeback wins and the load is dropped whatever the address. Loads never forward.
- dbg_data reflects the bank contents after the last edge and is not forwarded.

## Timing
- Latency is 2 cycles: instr presented in cycle k (sampled at edge k) appears on res_* after edge k+1. Throughput is 1 per cycle; there is no backpressure.
- in_valid = 0 inserts a bubble: res_valid = 0 two edges later, and the other res_* fields hold their previous value.
- Reset (any edge with rst = 1):
  - both pipeline valids, res_valid, res_ill and res_zf go to 0; res_rd and res_data go to 0;
  - every bank entry is cleared to 0;
  - in-flight instructions are discarded with no write;
  - in_valid and ld_en are ignored during the reset edge.
- Reset mid-stream: the first possible res_valid is 2 edges after the first non-reset edge with in_valid = 1.

## Test plan
1. Zero flag:
   - Stimulus: load r1 = 9, r2 = 9, then issue sub rd = 3, rs = 1, rt = 2.
   - Response: two edges later res_valid = 1, res_rd = 3, res_data = 0, res_zf = 1, and dbg r3 = 0.
2. Bypass:
   - Stimulus: with r1 = 9, r2 = 9, issue add r4 = r1 + r2 and, in the next cycle, add r5 = r4 + r1.
   - Response: results 18 then 27 on consecutive cycles; r5 = 27.
3. Register zero:
   - Stimulus: add rd = 0 (r1 + r2), then immediately add r6 = r0 + r1.
   - Response: first result 18 with r0 still 0; second result 9 (no forward from rd = 0).
4. slt and shifts:
   - Stimulus: load r7 = all ones, r8 = 1. Issue slt r9 = r7 < r8, then sll r10 = r8 << 4 (shamt 4).
   - Response: res_data 1, then 16.
5. Illegal:
   - Stimulus: funct 111111 with rd = 11, and separately op = 000001 with rd = 11.
   - Response: for each, res_valid = 1, res_ill = 1, res_data = 0, res_zf = 0, and r11 unchanged.
6. Priority and reset:
   - Stimulus: issue add r12 while ld_en targets r13 on the writeback edge. Then assert rst for one cycle with two instructions in flight.
   - Response: r12 is written and the r13 load is dropped. After reset res_valid stays 0 for 2 cycles and all dbg reads return 0.
